aes_mode_ctrl: RTL and testbench
================================

Name: aes_mode_ctrl

Overview:
- Parametrised block-chaining front end for the AES datapath.
- Packs an input word stream into 128-bit blocks and applies ECB, CBC or CTR chaining. Exchanges whole blocks with an external 128-bit cipher core over a request/response handshake, then unpacks results back onto a word stream.
- Successor to the fixed 32-bit, CBC-only engine. Adds run-time mode select, loadable IV/counter, and parametric word width.
- Sits between the HWPE streamers and the cipher core.

Parameters:
- WORD_W, 32, stream word width; legal values 32, 64, 128.
- CNT_W, 16, width of processed-block counter.
- NWORDS, 128/WORD_W, derived words per block; not overridable.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- clear_i  in  1  synchronous soft clear, same effect as reset except IV register
- mode_i  in  2  0=ECB, 1=CBC, 2=CTR, 3=reserved (treated as ECB); sampled only in IDLE
- iv_load_i  in  1  load iv_i into chain/counter register; honoured only in IDLE
- iv_i  in  128  IV (CBC) or initial counter (CTR)
- in_valid_i / in_ready_o  in/out  1  input word handshake
- in_data_i  in  WORD_W  input word; first word of a block = MSBs
- out_valid_o / out_ready_i  out/in  1  output word handshake
- out_data_o  out  WORD_W  output word; first word = MSBs
- core_req_o / core_gnt_i  out/in  1  block issue handshake
- core_block_o  out  128  block to cipher core
- core_rvalid_i  in  1  result strobe; always accepted, one cycle
- core_block_i  in  128  cipher result
- busy_o  out  1  high in any state except IDLE/FILL with zero words held
- block_cnt_o  out  CNT_W  completed output blocks, wraps modulo 2^CNT_W

Behaviour:
- Reset values:
  - Outputs: in_ready_o=0, out_valid_o=0, core_req_o=0, busy_o=0, block_cnt_o=0, data outputs 0.
  - Internal: chain register 0, mode latch ECB, state IDLE.
- FSM states and transitions:
  - IDLE -> FILL when in_valid_i=1. mode_i is latched on this transition.
  - FILL: in_ready_o=1. Each accepted word shifts into the buffer. On acceptance of word NWORDS-1 -> ISSUE.
  - ISSUE: core_req_o=1 with core_block_o stable until core_gnt_i. Then -> WAIT.
  - WAIT: on core_rvalid_i, compute the result block -> DRAIN.
  - DRAIN: out_valid_o=1. Words are presented MSB-first. out_data_o is held stable while out_ready_i=0. After the last word is accepted: block_cnt_o++, then -> FILL.
- Core input and result per mode:
  - ECB: core input = P; result = C_core.
  - CBC: core input = P xor chain; result = C_core; chain <= C_core.
  - CTR: core input = chain; result = C_core xor P; chain <= chain+1, modulo 2^128 wrap, computed at rvalid.
- Latency with zero-wait core (gnt same cycle, rvalid next cycle): last input word accepted at cycle t -> ISSUE at t+1 -> rvalid at t+2 -> first out_valid_o at t+3.
- No overlap: in_ready_o=0 outside FILL.
- Returning to IDLE: a return to IDLE occurs only via reset/clear. Between streams, software drives clear_i, then iv_load_i, then the new mode.
- clear_i mid-block: partial input and pending output are discarded, state returns to IDLE, and any in-flight core_rvalid_i is ignored. Chain register is retained unless iv_load_i is applied.
- rst_i mid-operation: immediate return to reset values; core result ignored.
- iv_load_i and in_valid_i both asserted in IDLE: the IV load takes effect first, and the word is accepted in FILL the next cycle.
- core_rvalid_i outside WAIT: ignored.
- WORD_W=128: NWORDS=1, and FILL/DRAIN each take one handshake.

Optional Feature:
- Macro: AES_MODE_CTRL_PREFETCH_EN.
- When defined: a second input buffer is added, and in_ready_o stays 1 during ISSUE/WAIT/DRAIN until the second buffer is full. After DRAIN completes, a full prefetched block goes straight to ISSUE, saving NWORDS fill cycles per block. Ordering and chain semantics are unchanged. clear_i flushes both buffers.
- When undefined: single buffer, behaviour exactly as above.

Test Plan:
All cases use an identity core stub (rvalid one cycle after gnt, returns core_block_o), WORD_W=32 unless stated.
- ECB, words 6bc1bee2 2e409f96 e93d7e11 7393172a -> output identical four words; block_cnt_o=1; first out_valid_o exactly 3 cycles after last input accept.
- CBC, IV 000102030405060708090a0b0c0d0e0f, same words -> 6bc0bce1 2a459991 e134741a 7f9e1925. Second block equal to the first -> output equals first block xor previous output.
- CTR, IV 00...00ffffffffffffffffffffffffffffffff-style all-ones counter, plaintext 0 -> block0 out = ffffffff x4, block1 out = 00000000 x4 (counter wrap).
- Backpressure: out_ready_i toggling pattern 1,0,0,1, and core_gnt_i delayed 5 cycles -> no word lost or duplicated; out_data_o stable while stalled.
- clear_i asserted after 2 of 4 input words, then 4 new ECB words -> only the new block is emitted; block_cnt_o=1.
- WORD_W=128 and PREFETCH_EN build, 8 back-to-back ECB blocks with out_ready_i=1 -> output throughput one block per 3 cycles after first.

Source files
------------

// File: rtl/aes_mode_ctrl.sv
// aes_mode_ctrl: packs a word stream into 128-bit blocks with ECB/CBC/CTR chaining.
// Build option AES_MODE_CTRL_PREFETCH_EN adds a second input buffer.
module aes_mode_ctrl #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic [1:0]        mode_i,
    input  logic              iv_load_i,
    input  logic [127:0]      iv_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WORD_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [WORD_W-1:0] out_data_o,
    output logic              core_req_o,
    input  logic              core_gnt_i,
    output logic [127:0]      core_block_o,
    input  logic              core_rvalid_i,
    input  logic [127:0]      core_block_i,
    output logic              busy_o,
    output logic [CNT_W-1:0]  block_cnt_o
);
    localparam int NWORDS = 128 / WORD_W;
    localparam int CW     = $clog2(NWORDS) + 1;
    localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_ISSUE, S_WAIT, S_DRAIN
    } state_t;

    typedef enum logic [1:0] {
        M_ECB = 2'd0, M_CBC = 2'd1, M_CTR = 2'd2, M_RSV = 2'd3
    } mode_t;

    state_t           state_q, state_d;
    mode_t            mode_q;
    logic [127:0]     chain_q, in_buf_q, out_buf_q;
    logic [CW-1:0]    wcnt_q, ocnt_q;
    logic [CNT_W-1:0] blk_cnt_q;
    logic [127:0]     in_shift, out_shift, core_in, result;
    logic             fill_fire, fill_last, out_fire, drain_last;
    logic             take_res, is_cbc, is_ctr, next_issue, pre_room;

    if (NWORDS == 1) begin : g_one
        assign in_shift  = in_data_i;
        assign out_shift = '0;
    end else begin : g_many
        assign in_shift  = {in_buf_q[127-WORD_W:0], in_data_i};
        assign out_shift = {out_buf_q[127-WORD_W:0], {WORD_W{1'b0}}};
    end

    assign fill_fire  = in_valid_i & (state_q == S_FILL);
    assign fill_last  = fill_fire & (wcnt_q == LAST);
    assign out_fire   = out_ready_i & (state_q == S_DRAIN);
    assign drain_last = out_fire & (ocnt_q == LAST);
    assign take_res   = core_rvalid_i & (state_q == S_WAIT);
    assign is_cbc     = (mode_q == M_CBC);
    assign is_ctr     = (mode_q == M_CTR);

`ifdef AES_MODE_CTRL_PREFETCH_EN
    localparam logic [CW-1:0] FULL = CW'(NWORDS);

    logic [127:0]  pbuf_q, pbuf_d, pre_shift;
    logic [CW-1:0] pcnt_q, pcnt_d;
    logic          pre_fire;

    if (NWORDS == 1) begin : g_pre_one
        assign pre_shift = in_data_i;
    end else begin : g_pre_many
        assign pre_shift = {pbuf_q[127-WORD_W:0], in_data_i};
    end

    assign pre_room   = (pcnt_q != FULL) &
                        (state_q inside {S_ISSUE, S_WAIT, S_DRAIN});
    assign pre_fire   = in_valid_i & pre_room;
    assign pbuf_d     = pre_fire ? pre_shift : pbuf_q;
    assign pcnt_d     = pre_fire ? pcnt_q + CW'(1) : pcnt_q;
    assign next_issue = (pcnt_d == FULL);

    // Second buffer collects the next block while the current one is in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pbuf_q <= '0;
            pcnt_q <= '0;
        end else if (clear_i || drain_last) begin
            pbuf_q <= '0;
            pcnt_q <= '0;
        end else begin
            pbuf_q <= pbuf_d;
            pcnt_q <= pcnt_d;
        end
    end
`else
    assign pre_room   = 1'b0;
    assign next_issue = 1'b0;
`endif

    // Next state and handshake outputs
    always_comb begin
        state_d     = state_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        core_req_o  = 1'b0;
        busy_o      = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (in_valid_i) state_d = S_FILL;
            end
            S_FILL: begin
                in_ready_o = 1'b1;
                busy_o     = (wcnt_q != '0);
                if (fill_last) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                in_ready_o = pre_room;
                core_req_o = 1'b1;
                if (core_gnt_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                in_ready_o = pre_room;
                if (core_rvalid_i) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                in_ready_o  = pre_room;
                out_valid_o = 1'b1;
                if (drain_last) state_d = next_issue ? S_ISSUE : S_FILL;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Per-mode core input and result block
    always_comb begin
        core_in = in_buf_q;
        result  = core_block_i;
        unique case (1'b1)
            is_cbc: core_in = in_buf_q ^ chain_q;
            is_ctr: begin
                core_in = chain_q;
                result  = core_block_i ^ in_buf_q;
            end
            default: ;
        endcase
    end

    assign core_block_o = core_req_o ? core_in : '0;
    assign out_data_o   = out_buf_q[127 -: WORD_W];
    assign block_cnt_o  = blk_cnt_q;

    // State register; clear and reset both force IDLE
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        state_q <= S_IDLE;
        else if (clear_i) state_q <= S_IDLE;
        else              state_q <= state_d;
    end

    // Block buffers and counters; soft clear drops partial and pending data
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q    <= M_ECB;
            in_buf_q  <= '0;
            out_buf_q <= '0;
            wcnt_q    <= '0;
            ocnt_q    <= '0;
            blk_cnt_q <= '0;
        end else if (clear_i) begin
            mode_q    <= M_ECB;
            in_buf_q  <= '0;
            out_buf_q <= '0;
            wcnt_q    <= '0;
            ocnt_q    <= '0;
            blk_cnt_q <= '0;
        end else begin
            if (state_q == S_IDLE && in_valid_i) mode_q <= mode_t'(mode_i);
            if (fill_fire) begin
                in_buf_q <= in_shift;
                wcnt_q   <= fill_last ? '0 : wcnt_q + CW'(1);
            end
            if (take_res) begin
                out_buf_q <= result;
                ocnt_q    <= '0;
            end else if (out_fire) begin
                out_buf_q <= out_shift;
                ocnt_q    <= drain_last ? '0 : ocnt_q + CW'(1);
            end
            if (drain_last) blk_cnt_q <= blk_cnt_q + CNT_W'(1);
`ifdef AES_MODE_CTRL_PREFETCH_EN
            if (drain_last) begin
                in_buf_q <= pbuf_d;
                wcnt_q   <= next_issue ? '0 : pcnt_d;
            end
`endif
        end
    end

    // Chain/counter register survives soft clear; only IV load rewrites it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chain_q <= '0;
        end else if (state_q == S_IDLE && iv_load_i) begin
            chain_q <= iv_i;
        end else if (!clear_i && take_res) begin
            if (is_cbc)      chain_q <= core_block_i;
            else if (is_ctr) chain_q <= chain_q + 128'd1;
        end
    end

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// tb_aes_mode_ctrl: scoreboard bench with identity cipher-core stubs.
// A second WORD_W=128 instance checks block-to-block throughput.
module tb_aes_mode_ctrl;
`ifdef AES_MODE_CTRL_PREFETCH_EN
    localparam int PERIOD = 3;
`else
    localparam int PERIOD = 4;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    logic         clear = 1'b0, iv_load = 1'b0;
    logic [1:0]   mode = 2'd0;
    logic [127:0] iv = '0;
    logic         in_valid = 1'b0, in_ready;
    logic [31:0]  in_data = '0;
    logic         out_valid, out_ready = 1'b1;
    logic [31:0]  out_data;
    logic         core_req, core_gnt, core_rvalid, busy;
    logic [127:0] core_blk_o, core_blk_i;
    logic [15:0]  blk_cnt;

    logic         clear2 = 1'b0;
    logic         in_valid2 = 1'b0, in_ready2, out_valid2;
    logic         out_ready2 = 1'b1;
    logic [127:0] in_data2 = '0, out_data2, blk2_o, blk2_i;
    logic         req2, gnt2, rv2, busy2;
    logic [15:0]  cnt2;
    logic [1:0]   mode2 = 2'd0;
    logic         iv_load2 = 1'b0;
    logic [127:0] iv2 = '0;

    aes_mode_ctrl #(.WORD_W(32), .CNT_W(16)) u_dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
        .mode_i(mode), .iv_load_i(iv_load), .iv_i(iv),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data),
        .core_req_o(core_req), .core_gnt_i(core_gnt),
        .core_block_o(core_blk_o),
        .core_rvalid_i(core_rvalid), .core_block_i(core_blk_i),
        .busy_o(busy), .block_cnt_o(blk_cnt)
    );

    aes_mode_ctrl #(.WORD_W(128), .CNT_W(16)) u_dut128 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear2),
        .mode_i(mode2), .iv_load_i(iv_load2), .iv_i(iv2),
        .in_valid_i(in_valid2), .in_ready_o(in_ready2),
        .in_data_i(in_data2),
        .out_valid_o(out_valid2), .out_ready_i(out_ready2),
        .out_data_o(out_data2),
        .core_req_o(req2), .core_gnt_i(gnt2),
        .core_block_o(blk2_o),
        .core_rvalid_i(rv2), .core_block_i(blk2_i),
        .busy_o(busy2), .block_cnt_o(cnt2)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // identity core stub for the 32-bit instance, grant after gnt_delay
    int           gnt_delay = 0;
    int           stall = 0;
    logic         stub_rv = 1'b0, inj_rv = 1'b0;
    logic [127:0] stub_blk = '0;
    logic         s1_f, s1_r;
    logic [127:0] s1_b;
    assign core_gnt    = core_req && (stall >= gnt_delay);
    assign core_rvalid = stub_rv | inj_rv;
    assign core_blk_i  = stub_blk;
    initial forever begin
        @(negedge clk);
        s1_f = core_req && core_gnt;
        s1_r = core_req;
        s1_b = core_blk_o;
        @(posedge clk);
        #1;
        stub_rv  = s1_f;
        stub_blk = s1_b;
        if (s1_f)      stall = 0;
        else if (s1_r) stall++;
    end

    // zero-wait identity core stub for the 128-bit instance
    logic         s2_f;
    logic [127:0] s2_b;
    logic         stub2_rv = 1'b0;
    logic [127:0] stub2_blk = '0;
    assign gnt2   = req2;
    assign rv2    = stub2_rv;
    assign blk2_i = stub2_blk;
    initial forever begin
        @(negedge clk);
        s2_f = req2 && gnt2;
        s2_b = blk2_o;
        @(posedge clk);
        #1;
        stub2_rv  = s2_f;
        stub2_blk = s2_b;
    end

    // output backpressure pattern 1,0,0,1
    logic       bp_en = 1'b0;
    logic [3:0] bp_pat = 4'b1001;
    int         bp_k = 0;
    initial forever begin
        @(posedge clk);
        #1;
        if (bp_en) begin
            out_ready = bp_pat[3-bp_k];
            bp_k = (bp_k + 1) % 4;
        end else begin
            out_ready = 1'b1;
        end
    end

    // scoreboard for the 32-bit instance
    logic [31:0] q[$];
    logic        stalled = 1'b0;
    logic [31:0] held = '0;
    int          acc_cyc = 0;
    initial forever begin
        @(negedge clk);
        if (in_valid && in_ready) acc_cyc = cyc;
        if (stalled) check("hold_data", out_data, held);
        stalled = out_valid && !out_ready;
        held    = out_data;
        if (out_valid && out_ready) begin
            check("sb_pending", q.size() != 0, 1'b1);
            if (q.size() != 0) check("out_word", out_data, q.pop_front());
        end
    end

    // scoreboard and block spacing for the 128-bit instance
    logic [127:0] q2[$];
    int           prev_cyc = 0;
    bit           have_prev = 1'b0;
    initial forever begin
        @(negedge clk);
        if (out_valid2 && out_ready2) begin
            check("sb2_pending", q2.size() != 0, 1'b1);
            if (q2.size() != 0) check("out_blk128", out_data2, q2.pop_front());
            if (have_prev) check("blk_period", cyc - prev_cyc, PERIOD);
            prev_cyc  = cyc;
            have_prev = 1'b1;
        end
    end

    task automatic push_blk(input logic [127:0] b);
        for (int i = 0; i < 4; i++) q.push_back(b[127-32*i -: 32]);
    endtask

    task automatic put_word(input logic [31:0] w);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 300);
        check("in_accept", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_blk(input logic [127:0] b);
        for (int i = 0; i < 4; i++) put_word(b[127-32*i -: 32]);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drained", q.size(), 0);
        @(negedge clk);
    endtask

    task automatic start_stream(input logic [1:0] m, input logic [127:0] v);
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        iv_load = 1'b1;
        iv      = v;
        mode    = m;
        @(posedge clk);
        #1 iv_load = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 1'b0);
        check("idle_cnt", blk_cnt, 0);
    endtask

    task automatic put_blk2(input logic [127:0] b);
        int n = 0;
        q2.push_back(b);
        in_valid2 = 1'b1;
        in_data2  = b;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready2 && n < 100);
        check("in2_accept", in_ready2, 1'b1);
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
    endtask

    task automatic run_tput();
        int n = 0;
        for (int k = 0; k < 8; k++)
            put_blk2({$urandom, $urandom, $urandom, $urandom});
        while (q2.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drained128", q2.size(), 0);
        @(negedge clk);
        check("cnt128", cnt2, 8);
    endtask

    task automatic latency_check();
        int n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ecb_latency", cyc - acc_cyc, 3);
    endtask

    logic [127:0] p, c1, r;

    initial begin
        p  = 128'h6bc1bee2_2e409f96_e93d7e11_7393172a;
        c1 = 128'h6bc0bce1_2a459991_e134741a_7f9e1925;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_core_req", core_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_cnt", blk_cnt, 0);
        check("rst_out_data", out_data, 0);
        check("rst_core_blk", core_blk_o, 0);

        start_stream(2'd0, '0);
        push_blk(p);
        send_blk(p);
        latency_check();
        wait_done();
        check("ecb_cnt", blk_cnt, 1);

        start_stream(2'd1, 128'h00010203_04050607_08090a0b_0c0d0e0f);
        push_blk(c1);
        send_blk(p);
        push_blk(p ^ c1);
        send_blk(p);
        wait_done();
        check("cbc_cnt", blk_cnt, 2);

        start_stream(2'd2, '1);
        push_blk('1);
        send_blk('0);
        push_blk('0);
        send_blk('0);
        wait_done();
        check("ctr_cnt", blk_cnt, 2);

        gnt_delay = 5;
        bp_en     = 1'b1;
        start_stream(2'd0, '0);
        for (int b = 0; b < 2; b++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            push_blk(r);
            send_blk(r);
        end
        wait_done();
        check("bp_cnt", blk_cnt, 2);
        bp_en     = 1'b0;
        gnt_delay = 0;

        start_stream(2'd0, '0);
        put_word($urandom);
        put_word($urandom);
        @(negedge clk);
        check("part_busy", busy, 1'b1);
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        check("clr_busy", busy, 1'b0);
        check("clr_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1 inj_rv = 1'b1;
        @(posedge clk);
        #1 inj_rv = 1'b0;
        repeat (2) @(negedge clk);
        check("stray_rvalid", out_valid, 1'b0);
        r = {$urandom, $urandom, $urandom, $urandom};
        push_blk(r);
        send_blk(r);
        wait_done();
        check("clr_cnt", blk_cnt, 1);

        run_tput();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: no finish, %0d checks so far", n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
